// File: rtl/vault_pkg.sv
// Shared types and constants for the vault supervisor slice.
package vault_pkg;

  typedef enum logic [1:0] {
    MONITOR = 2'd0,
    LOCKOUT = 2'd1,
    OPEN    = 2'd2,
    ALARM   = 2'd3
  } sup_state_t;

  localparam int unsigned DEF_MAX_FAILS      = 3;
  localparam int unsigned DEF_MAX_LOCKOUTS   = 2;
  localparam int unsigned DEF_LOCKOUT_CYCLES = 50_000_000;
  localparam int unsigned DEF_OPEN_TIMEOUT   = 500_000_000;

  // Segment patterns (gfedcba, active high) showing the state as digits 0..3.
  localparam logic [6:0] SEG_MONITOR = 7'h3F;
  localparam logic [6:0] SEG_LOCKOUT = 7'h06;
  localparam logic [6:0] SEG_OPEN    = 7'h5B;
  localparam logic [6:0] SEG_ALARM   = 7'h4F;

  function automatic logic [6:0] sup_state_seg(input sup_state_t s);
    logic [6:0] seg;
    case (s)
      MONITOR: seg = SEG_MONITOR;
      LOCKOUT: seg = SEG_LOCKOUT;
      OPEN:    seg = SEG_OPEN;
      ALARM:   seg = SEG_ALARM;
      default: seg = '0;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/vault_supervisor_timer.sv
// Loadable down-counter shared by the lockout and open-timeout phases.
module vault_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] r_count;

  // Load on request, otherwise count down and hold at zero.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign expired = (r_count == '0);

endmodule

// File: rtl/vault_supervisor.sv
// Supervisor around the vault lock FSM: fail counting, timed lockout,
// alarm escalation and open-too-long relock request.
module vault_supervisor
  import vault_pkg::*;
#(
  parameter int unsigned MAX_FAILS      = DEF_MAX_FAILS,
  parameter int unsigned MAX_LOCKOUTS   = DEF_MAX_LOCKOUTS,
  parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter int unsigned OPEN_TIMEOUT   = DEF_OPEN_TIMEOUT
) (
  input  logic                               clock,
  input  logic                               n_reset,
  input  logic                               i_vault_locked,
  input  logic                               i_vault_progress,
  input  logic                               i_vault_unlocked,
  input  logic                               i_clear_alarm,
  output logic                               o_ctrl_enable,
  output logic                               o_alarm,
  output logic                               o_relock_req,
  output logic [$clog2(MAX_FAILS+1)-1:0]     o_fail_count,
  output logic [1:0]                         o_sup_state
);

  localparam int unsigned FC_W      = $clog2(MAX_FAILS + 1);
  localparam int unsigned LC_W      = $clog2(MAX_LOCKOUTS + 1);
  localparam int unsigned TIMER_MAX = (LOCKOUT_CYCLES > OPEN_TIMEOUT) ? LOCKOUT_CYCLES : OPEN_TIMEOUT;
  localparam int unsigned TIMER_W   = $clog2(TIMER_MAX);

  localparam logic [FC_W-1:0]    FAIL_LAST     = FC_W'(MAX_FAILS - 1);
  localparam logic [LC_W-1:0]    LOCKOUT_LIMIT = LC_W'(MAX_LOCKOUTS);
  localparam logic [TIMER_W-1:0] LOCKOUT_LOAD  = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OPEN_LOAD     = TIMER_W'(OPEN_TIMEOUT - 1);

  sup_state_t        r_state;
  sup_state_t        w_next_state;
  logic [FC_W-1:0]   r_fail_count;
  logic [FC_W-1:0]   w_next_fail_count;
  logic [LC_W-1:0]   r_lockout_cnt;
  logic [LC_W-1:0]   w_next_lockout_cnt;
  logic [LC_W-1:0]   w_lockout_inc;
  logic              r_prev_progress;
  logic              r_relock_req;
  logic              r_relock_done;
  logic              w_fail_event;
  logic              w_relock_fire;
  logic              w_timer_load;
  logic [TIMER_W-1:0] w_timer_load_value;
  logic              w_timer_expired;

  assign w_fail_event  = i_vault_locked & r_prev_progress;
  assign w_lockout_inc = r_lockout_cnt + LC_W'(1);

  // Expiry stays asserted while the timer sits at zero, so a done flag
  // limits the relock request to a single pulse per OPEN visit.
  assign w_relock_fire = (r_state == OPEN) & w_timer_expired & i_vault_unlocked & ~r_relock_done;

  vault_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clock      (clock),
    .n_reset    (n_reset),
    .load       (w_timer_load),
    .load_value (w_timer_load_value),
    .expired    (w_timer_expired)
  );

  // State, counters, progress history and relock pulse registers.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state         <= MONITOR;
      r_fail_count    <= '0;
      r_lockout_cnt   <= '0;
      r_prev_progress <= 1'b0;
      r_relock_req    <= 1'b0;
      r_relock_done   <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_fail_count    <= w_next_fail_count;
      r_lockout_cnt   <= w_next_lockout_cnt;
      r_prev_progress <= i_vault_progress;
      r_relock_req    <= w_relock_fire;
      if (w_timer_load) begin
        r_relock_done <= 1'b0;
      end else if (w_relock_fire) begin
        r_relock_done <= 1'b1;
      end
    end
  end

  // Next-state, counter updates and timer load requests.
  always_comb begin
    w_next_state       = r_state;
    w_next_fail_count  = r_fail_count;
    w_next_lockout_cnt = r_lockout_cnt;
    w_timer_load       = 1'b0;
    w_timer_load_value = LOCKOUT_LOAD;
    case (r_state)
      MONITOR: begin
        if (i_vault_unlocked) begin
          w_next_state       = OPEN;
          w_next_fail_count  = '0;
          w_next_lockout_cnt = '0;
          w_timer_load       = 1'b1;
          w_timer_load_value = OPEN_LOAD;
        end else if (w_fail_event) begin
          if (r_fail_count == FAIL_LAST) begin
            w_next_fail_count  = '0;
            w_next_lockout_cnt = w_lockout_inc;
            if (w_lockout_inc == LOCKOUT_LIMIT) begin
              w_next_state = ALARM;
            end else begin
              w_next_state = LOCKOUT;
              w_timer_load = 1'b1;
            end
          end else begin
            w_next_fail_count = r_fail_count + FC_W'(1);
          end
        end
      end
      LOCKOUT: begin
        if (w_timer_expired) begin
          w_next_state = MONITOR;
        end
      end
      OPEN: begin
        if (i_vault_locked) begin
          w_next_state = MONITOR;
        end
      end
      ALARM: begin
        if (i_clear_alarm) begin
          w_next_state       = MONITOR;
          w_next_fail_count  = '0;
          w_next_lockout_cnt = '0;
        end
      end
      default: begin
        w_next_state = MONITOR;
      end
    endcase
  end

  assign o_ctrl_enable = (r_state == MONITOR) | (r_state == OPEN);
  assign o_alarm       = (r_state == ALARM);
  assign o_relock_req  = r_relock_req;
  assign o_fail_count  = r_fail_count;
  assign o_sup_state   = r_state;

endmodule

// File: doc/vault_supervisor.md
# vault_supervisor

Supervisory controller wrapped around the vault combination-lock FSM. It watches the lock's state indications, counts failed dial attempts, and gates the rotary input with a timed lockout. It escalates repeated lockouts to an alarm and requests an automatic relock if the vault is left open too long. It sits between the rotary-encoder front end and the lock FSM at the same top level, on the same clock.

## Interface
- MAX_FAILS, default 3: consecutive failed attempts that trigger a lockout (≥1).
- MAX_LOCKOUTS, default 2: consecutive lockouts that escalate to alarm (≥1).
- LOCKOUT_CYCLES, default 50_000_000: lockout duration in clocks (1 s at 50 MHz; ≥2).
- OPEN_TIMEOUT, default 500_000_000: clocks allowed in unlocked before a relock request (≥2).
- clock  input  1  system clock, rising edge.
- n_reset  input  1  asynchronous, active-low reset.
- vault_locked  input  1  lock FSM is in locked.
- vault_progress  input  1  lock FSM is in uptocomb1, downtocomb1 or uptocomb2.
- vault_unlocked  input  1  lock FSM is in unlocked.
- clear_alarm  input  1  supervisor key, synchronous level; acted on only in ALARM.
- ctrl_enable  output  1  1 = pass rotary direction/code to the lock FSM; 0 = top level holds the input idle.
- alarm  output  1  alarm indicator.
- relock_req  output  1  one-cycle pulse; top level forces the lock FSM to locked.
- fail_count  output  $clog2(MAX_FAILS+1)  current consecutive-failure count.
- sup_state  output  2  encoded supervisor state, for LED/7-seg display.

## Operation
- Fail event: vault_locked=1 while the registered previous-cycle vault_progress=1. This covers any drop from a combination state back to locked. The lock_reset→locked path is not a failure.
- Open event: vault_unlocked=1 in MONITOR. If an open event and a fail event occur in the same cycle, open wins.
- States (sup_state encoding): MONITOR=0, LOCKOUT=1, OPEN=2, ALARM=3.
- MONITOR: ctrl_enable=1.
  - Open event → OPEN. Clear fail_count and lockout_cnt.
  - Fail event with fail_count<MAX_FAILS-1 → increment fail_count, stay in MONITOR.
  - Fail event with fail_count=MAX_FAILS-1 → increment lockout_cnt and clear fail_count. If the new lockout_cnt=MAX_LOCKOUTS, go to ALARM; otherwise go to LOCKOUT and load the timer.
- LOCKOUT: ctrl_enable=0, all inputs ignored. When the timer expires → MONITOR. lockout_cnt is retained; it clears only on a successful open or on clear_alarm.
- OPEN: ctrl_enable=1, timer loaded with OPEN_TIMEOUT on entry.
  - vault_locked=1 → MONITOR (normal relock).
  - Timer expiry while still unlocked → relock_req pulses for exactly one cycle; the block stays in OPEN until vault_locked=1. The timer does not reload.
- ALARM: ctrl_enable=0, alarm=1. clear_alarm=1 → MONITOR, clearing fail_count and lockout_cnt. No other exit.
- clear_alarm outside ALARM has no effect.
- Reset values: state=MONITOR, ctrl_enable=1, alarm=0, relock_req=0, fail_count=0, lockout_cnt=0, timer=0, prev_progress=0. Reset mid-lockout or mid-alarm returns immediately to MONITOR.

## Timing
- Moore outputs: ctrl_enable, alarm and sup_state decode from the state register and change one clock after the triggering input edge.
- relock_req is registered. It is high during the cycle after the timer reaches 0 and low the next cycle.
- Timer: down-counter loaded with N-1 on state entry, decremented each cycle. Expiry at 0 gives exactly N cycles in LOCKOUT with ctrl_enable=0.
- OPEN: relock_req asserts OPEN_TIMEOUT cycles after entry.
- fail_count updates at the same edge as the state transition caused by the fail event.
- Timer width is $clog2(max(LOCKOUT_CYCLES, OPEN_TIMEOUT)). No wrap: the counter holds at 0.

## Structure
- Package vault_pkg:
  - sup_state_t enum {MONITOR, LOCKOUT, OPEN, ALARM} with explicit 2-bit encoding.
  - Default parameter constants.
  - sup_state 7-seg display constants.
- Sub-module vault_timer: parameterised down-counter with ports clock, n_reset, load, load_value, expired. It is instantiated once and shared by LOCKOUT and OPEN.

## Test plan
Bench parameters: MAX_FAILS=3, MAX_LOCKOUTS=2, LOCKOUT_CYCLES=10, OPEN_TIMEOUT=20.
- Reset: hold n_reset low mid-stream → all outputs at reset values, sup_state=0, ctrl_enable=1.
- Three progress→locked drops → fail_count goes 1, 2, then 0. sup_state=1 and ctrl_enable=0 for exactly 10 cycles, then sup_state=0.
- Repeat three failures after the first lockout → sup_state=3 and alarm=1, held for more than 100 cycles. Pulse clear_alarm → MONITOR, fail_count=0, alarm=0.
- Two failures, then vault_unlocked → sup_state=2, fail_count=0. Hold unlocked for 20 cycles → relock_req high for one cycle. Then vault_locked → sup_state=0.
- Simultaneous fail event and vault_unlocked in MONITOR → OPEN, fail_count=0. clear_alarm in MONITOR → no change.
- n_reset asserted at cycle 5 of LOCKOUT → MONITOR, ctrl_enable=1, counters 0.
